// File: rtl/transmission_estimator.sv
// Streaming dark-channel transmission estimator: channel min, 3x3 spatial min with
// border masking, then t = 255 - omega*m. One output per input pixel, raster order.
module transmission_estimator #(
    parameter int unsigned IMG_WIDTH  = 512,
    parameter int unsigned IMG_HEIGHT = 512,
    parameter int unsigned OMEGA_Q8   = 243
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] input_pixel,
    input  logic        input_is_valid,
    output logic [7:0]  transmission,
    output logic        trans_valid
);

    localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT + 2);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FLUSH_END = ROW_W'(IMG_HEIGHT + 1);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;

    logic               a_beat_q, a_beat_d;
    logic [7:0]         a_pix_q, a_pix_d;
    logic [COL_W-1:0]   a_col_q, a_col_d;
    logic [ROW_W-1:0]   a_row_q, a_row_d;

    logic [2:0][2:0][7:0] win_q, win_d;
    logic               b_valid_q, b_valid_d;
    logic [COL_W-1:0]   b_cc_q, b_cc_d;
    logic [ROW_W-1:0]   b_cr_q, b_cr_d;

    logic               c_valid_q, c_valid_d;
    logic [7:0]         c_m_q, c_m_d;

    logic               tv_q, tv_d;
    logic [7:0]         trans_q, trans_d;

    logic [7:0]         lb1_mem [IMG_WIDTH];
    logic [7:0]         lb2_mem [IMG_WIDTH];
    logic [7:0]         lb1_rd, lb2_rd;
    logic [15:0]        prod;
    logic [7:0]         scaled;

    // Beat generation, raster counters and flush sequencing (flush runs row H and (H+1,0))
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        a_beat_d = 1'b0;
        a_pix_d  = 8'hFF;
        a_col_d  = col_q;
        a_row_d  = row_q;
        case (state_q)
            S_RUN: begin
                if (input_is_valid) begin
                    a_beat_d = 1'b1;
                    a_pix_d  = min8(min8(input_pixel[7:0], input_pixel[15:8]), input_pixel[23:16]);
                end
            end
            S_FLUSH: a_beat_d = 1'b1;
            default: state_d = S_RUN;
        endcase
        if (a_beat_d) begin
            if (state_q == S_FLUSH && row_q == ROW_FLUSH_END) begin
                col_d   = '0;
                row_d   = '0;
                state_d = S_RUN;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
                if (state_q == S_RUN && row_q == ROW_LAST) begin
                    state_d = S_FLUSH;
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    assign lb1_rd = lb1_mem[a_col_q];
    assign lb2_rd = lb2_mem[a_col_q];

    // Window shift; centre sits one line and one column behind the newest pixel
    always_comb begin
        win_d     = win_q;
        b_valid_d = 1'b0;
        b_cc_d    = b_cc_q;
        b_cr_d    = b_cr_q;
        if (a_beat_q) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][2] = win_q[r][1];
                win_d[r][1] = win_q[r][0];
            end
            win_d[0][0] = lb2_rd;
            win_d[1][0] = lb1_rd;
            win_d[2][0] = a_pix_q;
            if (a_col_q != '0) begin
                b_cc_d    = a_col_q - COL_W'(1);
                b_cr_d    = a_row_q - ROW_W'(1);
                b_valid_d = (a_row_q != '0);
            end else begin
                b_cc_d    = COL_LAST;
                b_cr_d    = a_row_q - ROW_W'(2);
                b_valid_d = (a_row_q >= ROW_W'(2));
            end
        end
    end

    // Masked 3x3 min: row 0 = above, row 2 = below, col 2 = left, col 0 = right
    always_comb begin
        logic top, bot, lft, rgt;
        top     = (b_cr_q == '0);
        bot     = (b_cr_q == ROW_LAST);
        lft     = (b_cc_q == '0);
        rgt     = (b_cc_q == COL_LAST);
        c_m_d   = 8'hFF;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!((r == 0 && top) || (r == 2 && bot) || (c == 2 && lft) || (c == 0 && rgt))) begin
                    c_m_d = min8(c_m_d, win_q[r][c]);
                end
            end
        end
        c_valid_d = b_valid_q;
        if (!b_valid_q) begin
            c_m_d = c_m_q;
        end
    end

    assign prod   = 16'(c_m_q) * 16'(OMEGA_Q8);
    assign scaled = 8'(prod >> 8);

    // Output stage; value holds between pulses
    always_comb begin
        tv_d    = c_valid_q;
        trans_d = c_valid_q ? (8'hFF - scaled) : trans_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RUN;
            col_q     <= '0;
            row_q     <= '0;
            a_beat_q  <= 1'b0;
            a_pix_q   <= 8'hFF;
            a_col_q   <= '0;
            a_row_q   <= '0;
            win_q     <= '1;
            b_valid_q <= 1'b0;
            b_cc_q    <= '0;
            b_cr_q    <= '0;
            c_valid_q <= 1'b0;
            c_m_q     <= 8'hFF;
            tv_q      <= 1'b0;
            trans_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            a_beat_q  <= a_beat_d;
            a_pix_q   <= a_pix_d;
            a_col_q   <= a_col_d;
            a_row_q   <= a_row_d;
            win_q     <= win_d;
            b_valid_q <= b_valid_d;
            b_cc_q    <= b_cc_d;
            b_cr_q    <= b_cr_d;
            c_valid_q <= c_valid_d;
            c_m_q     <= c_m_d;
            tv_q      <= tv_d;
            trans_q   <= trans_d;
        end
    end

    // Line buffers: lb1 holds the previous line, lb2 the one before; contents never cleared
    always_ff @(posedge clk) begin
        if (a_beat_q) begin
            lb1_mem[a_col_q] <= a_pix_q;
            lb2_mem[a_col_q] <= lb1_mem[a_col_q];
        end
    end

    assign transmission = trans_q;
    assign trans_valid  = tv_q;

endmodule

// File: tb/tb_transmission_estimator.sv
// Scoreboard bench for transmission_estimator at 8x4: directed frames push expected
// values into a queue, a negedge monitor pops and compares on every trans_valid pulse.
module tb_transmission_estimator;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] input_pixel = '0;
    logic        input_is_valid = 1'b0;
    logic [7:0]  transmission;
    logic        trans_valid;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          pushed = 0;
    int          cyc = 0;
    int          last_in_cyc = 0;
    int          last_out_cyc = 0;
    logic [7:0]  hold_exp = 8'h00;
    logic [7:0]  exp_q [$];

    transmission_estimator #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .OMEGA_Q8  (243)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .input_pixel   (input_pixel),
        .input_is_valid(input_is_valid),
        .transmission  (transmission),
        .trans_valid   (trans_valid)
    );

    always #5 clk = ~clk;

    // Monitor: pulses are checked against the queue; idle cycles check the held value
    always @(negedge clk) begin
        logic [7:0] e;
        if (input_is_valid) last_in_cyc = cyc;
        if (trans_valid === 1'b1) begin
            pulses++;
            last_out_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: transmission=%0d, required no pulse", transmission);
            end else begin
                e = exp_q.pop_front();
                if (transmission !== e) begin
                    errors++;
                    $display("FAIL pixel_out_%0d: got %0d, required %0d", pulses - 1, transmission, e);
                end
                hold_exp = e;
            end
        end else if (rst) begin
            hold_exp = 8'h00;
        end else begin
            checks++;
            if (transmission !== hold_exp) begin
                errors++;
                $display("FAIL hold: got %0d, required %0d", transmission, hold_exp);
            end
        end
        cyc++;
    end

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic drive(input logic [23:0] p);
        @(posedge clk); #1;
        input_pixel    = p;
        input_is_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            input_is_valid = 1'b0;
            input_pixel    = 24'($urandom);
        end
    endtask

    // Background frame with an optional spot pixel; outputs within 1 row/col of the spot get e_spot
    task automatic send_frame(input logic [23:0] bg, input logic [23:0] spot, input int zr, input int zc,
                              input logic [7:0] e_bg, input logic [7:0] e_spot, input bit sparse, input int n_pix);
        if (n_pix == W * H) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    if (r - zr >= -1 && r - zr <= 1 && c - zc >= -1 && c - zc <= 1) exp_q.push_back(e_spot);
                    else exp_q.push_back(e_bg);
                    pushed++;
                end
            end
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r * W + c < n_pix) begin
                    if (sparse) begin
                        int g = 0;
                        while ($urandom_range(1, 0) == 1 && g < 4) g++;
                        idle(g);
                    end
                    drive((r == zr && c == zc) ? spot : bg);
                end
            end
        end
        @(posedge clk); #1;
        input_is_valid = 1'b0;
        if (n_pix == W * H) idle(W + 8);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", int'(trans_valid), 0);
        check("reset_trans", int'(transmission), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        send_frame({8'd100, 8'd100, 8'd100}, {8'd100, 8'd100, 8'd100}, -10, -10, 8'd161, 8'd161, 1'b0, W * H);
        send_frame(24'h000000, 24'h000000, -10, -10, 8'd255, 8'd255, 1'b0, W * H);
        send_frame(24'hFFFFFF, 24'hFFFFFF, -10, -10, 8'd13, 8'd13, 1'b0, W * H);
        send_frame({8'd120, 8'd200, 8'd50}, {8'd120, 8'd200, 8'd50}, -10, -10, 8'd208, 8'd208, 1'b0, W * H);
        send_frame({8'd30, 8'd200, 8'd200}, {8'd30, 8'd200, 8'd200}, -10, -10, 8'd227, 8'd227, 1'b0, W * H);
        send_frame({8'd90, 8'd10, 8'd90}, {8'd90, 8'd10, 8'd90}, -10, -10, 8'd246, 8'd246, 1'b0, W * H);
        send_frame({3{8'd200}}, 24'h000000, 1, 3, 8'd66, 8'd255, 1'b0, W * H);
        check("dense_latency", last_out_cyc - last_in_cyc, W + 5);
        send_frame({3{8'd200}}, 24'h000000, 2, 0, 8'd66, 8'd255, 1'b0, W * H);
        send_frame({3{8'd200}}, 24'h000000, 3, 7, 8'd66, 8'd255, 1'b0, W * H);
        send_frame({3{8'd200}}, 24'h000000, 0, 0, 8'd66, 8'd255, 1'b0, W * H);

        send_frame({3{8'd200}}, 24'h000000, 1, 3, 8'd66, 8'd255, 1'b1, W * H);
        // last_in is sampled one negedge before its accept edge, hence W+1 flush + 3 + 1
        check("sparse_latency", last_out_cyc - last_in_cyc, W + 5);
        check("pulse_count", pulses, pushed);

        // Partial frame of 10 pixels, then reset mid-frame
        send_frame({3{8'd200}}, 24'h000000, 1, 3, 8'd66, 8'd255, 1'b0, 10);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("midreset_valid", int'(trans_valid), 0);
            check("midreset_trans", int'(transmission), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        send_frame({3{8'd200}}, 24'h000000, 1, 3, 8'd66, 8'd255, 1'b0, W * H);

        idle(20);
        check("queue_drained", exp_q.size(), 0);
        check("total_pulses", pulses, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
